// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor d = a - b, LSB first, one full-subtractor cell plus a borrow flop.
// Optional macro SERIAL_SUB_SAT_EN: clamp d to zero when the final borrow is set.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
);
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   sa, sb;
    logic [W-2:0]   sr;
    logic [CW-1:0]  cnt;
    logic           br;
    logic           ai, bi, di, br_nxt, last;
    logic [W-1:0]   res_nxt;

    // Full-subtractor cell on the current LSBs
    assign ai      = sa[0];
    assign bi      = sb[0];
    assign di      = ai ^ bi ^ br;
    assign br_nxt  = (~ai & bi) | (~(ai ^ bi) & br);
    assign res_nxt = {di, sr};
    assign last    = (cnt == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa  <= '0;
            sb  <= '0;
            sr  <= '0;
            cnt <= '0;
            br  <= 1'b0;
            d   <= '0;
            bo  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa  <= a;
                    sb  <= b;
                    br  <= 1'b0;
                    cnt <= '0;
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    sr  <= res_nxt[W-1:1];
                    br  <= br_nxt;
                    cnt <= cnt + CW'(1);
                    // d/bo only move here, so they hold through IDLE and the next RUN
                    if (last) begin
`ifdef SERIAL_SUB_SAT_EN
                        d <= br_nxt ? '0 : res_nxt;
`else
                        d <= res_nxt;
`endif
                        bo <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub (W=8 instance plus a W=4 instance for the exhaustive sweep).
module tb_serial_sub;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, bo;
    logic [7:0] d;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bo4;
    logic [3:0] d4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_sub #(.W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .bo(bo)
    );

    serial_sub #(.W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .d(d4), .bo(bo4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one W=8 op; lat = edges after acceptance until done seen, -1 on timeout
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, output int lat);
        a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic do_op4(input logic [3:0] ia, input logic [3:0] ib, output int lat);
        a4 = ia; b4 = ib; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done4) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        checks++;
        if ({busy, done, d, bo} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b d=%h bo=%b want all 0", busy, done, d, bo);
        end
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int busy_cnt, done_cnt, done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        a = 8'h5A; b = 8'h3C; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
                checks++;
                if (d !== 8'h1E || bo !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_result got d=%h bo=%b want d=1e bo=0", d, bo);
                end
            end
            tick();
        end
        checks++;
        if (busy_cnt != 9) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d want 9", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || done_at != 9) begin
            errors++;
            $display("FAIL basic_done_timing got count=%0d at sample %0d want 1 at 9", done_cnt, done_at);
        end
    endtask

    task automatic test_borrow();
        int lat;
        logic [7:0] exp_d;
`ifdef SERIAL_SUB_SAT_EN
        exp_d = 8'h00;
`else
        exp_d = 8'hFF;
`endif
        do_op(8'h00, 8'h01, lat);
        checks++;
        if (lat != 8 || d !== exp_d || bo !== 1'b1) begin
            errors++;
            $display("FAIL borrow_0_minus_1 got lat=%0d d=%h bo=%b want lat=8 d=%h bo=1", lat, d, bo, exp_d);
        end
        tick();
        checks++;
        if (d !== exp_d || bo !== 1'b1) begin
            errors++;
            $display("FAIL borrow_hold_idle got d=%h bo=%b want d=%h bo=1", d, bo, exp_d);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_op(8'hFF, 8'hFF, lat);
        checks++;
        if (lat != 8 || d !== 8'h00 || bo !== 1'b0) begin
            errors++;
            $display("FAIL ff_minus_ff got lat=%0d d=%h bo=%b want lat=8 d=00 bo=0", lat, d, bo);
        end
        tick();
        a = 8'h80; b = 8'h7F; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'h00; b = 8'hFF;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (!done) begin
                checks++;
                if (d !== 8'h00 || bo !== 1'b0) begin
                    errors++;
                    $display("FAIL hold_during_run sample %0d got d=%h bo=%b want d=00 bo=0", k, d, bo);
                end
            end
            tick();
            if (done) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat != 8 || d !== 8'h01 || bo !== 1'b0) begin
            errors++;
            $display("FAIL 80_minus_7f got lat=%0d d=%h bo=%b want lat=8 d=01 bo=0", lat, d, bo);
        end
        tick();
    endtask

    task automatic test_start_ignored();
        int done_cnt, lat;
        done_cnt = 0;
        a = 8'h10; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12 && !done; k++) tick();
        checks++;
        if (!done || d !== 8'h0F || bo !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run_start got done=%b d=%h bo=%b want done=1 d=0f bo=0", done, d, bo);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (done || busy) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt != 0 || d !== 8'h0F) begin
            errors++;
            $display("FAIL ignore_done_start got extra busy/done=%0d d=%h want 0 and d=0f", done_cnt, d);
        end
        do_op(8'hAA, 8'h55, lat);
        checks++;
        if (lat != 8 || d !== 8'h55 || bo !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_after got lat=%0d d=%h bo=%b want lat=8 d=55 bo=0", lat, d, bo);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int done_cnt, lat;
        done_cnt = 0;
        a = 8'h20; b = 8'h03; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, d, bo} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b d=%h bo=%b want all 0", busy, done, d, bo);
        end
        tick();
        #2 rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL no_done_after_reset got %0d busy/done samples want 0", done_cnt);
        end
        do_op(8'h20, 8'h03, lat);
        checks++;
        if (lat != 8 || d !== 8'h1D || bo !== 1'b0) begin
            errors++;
            $display("FAIL fresh_after_reset got lat=%0d d=%h bo=%b want lat=8 d=1d bo=0", lat, d, bo);
        end
        tick();
    endtask

    task automatic test_sweep_w4();
        int lat;
        logic [3:0] exp_d;
        logic       exp_bo;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                exp_d  = 4'(i - j);
                exp_bo = (i < j);
`ifdef SERIAL_SUB_SAT_EN
                if (exp_bo) exp_d = 4'h0;
`endif
                do_op4(4'(i), 4'(j), lat);
                checks++;
                if (lat != 4 || d4 !== exp_d || bo4 !== exp_bo) begin
                    errors++;
                    $display("FAIL sweep_w4 a=%h b=%h got lat=%0d d=%h bo=%b want lat=4 d=%h bo=%b",
                             4'(i), 4'(j), lat, d4, bo4, exp_d, exp_bo);
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid_op();
        test_sweep_w4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
